// File: rtl/outputc_pkg.sv
// Shared constants and types for the router output-channel stage.
//   DATAW / VCHW / PORTW are MSB indices: a flit is DATAW+1 bits wide,
//   a VC id VCHW+1 bits, a port id PORTW+1 bits, and per-VC vectors VCH+1 bits.
//   The flit type field sits in the two LSBs of every flit.
package outputc_pkg;

    localparam int DATAW    = 31;
    localparam int DATAW_P1 = DATAW + 1;
    localparam int VCH      = 1;
    localparam int VCHW     = 0;
    localparam int PORTW    = 2;
    localparam int NIN      = 5;

    localparam int TYPE_MSB = 1;
    localparam int TYPE_LSB = 0;

    localparam logic [1:0] TYPE_HEAD     = 2'b10;
    localparam logic [1:0] TYPE_BODY     = 2'b00;
    localparam logic [1:0] TYPE_TAIL     = 2'b11;
    localparam logic [1:0] TYPE_HEADTAIL = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // A flit closes its packet when it is a tail or a single-flit packet.
    function automatic logic is_tail(input logic [DATAW:0] flit);
        logic [1:0] ftype;
        ftype = flit[TYPE_MSB:TYPE_LSB];
        return (ftype == TYPE_TAIL) || (ftype == TYPE_HEADTAIL);
    endfunction

endpackage

// File: rtl/outputc_rr_arb5.sv
// 5-way round-robin arbiter (purely combinational).
//   cand    : request vector, one bit per input channel
//   rr_last : index of the most recently granted input (0..4); the search
//             starts at rr_last+1 and wraps, so rr_last has lowest priority
//   gnt     : one-hot grant (all zero when no candidate)
//   index   : binary index of the granted input (0 when no candidate)
module rr_arb5
    import outputc_pkg::*;
(
    input  logic [4:0] cand,
    input  logic [2:0] rr_last,
    output logic [4:0] gnt,
    output logic [2:0] index
);

    logic [2:0] base_s;
    logic [2:0] pos_s;
    logic       found_s;
    int         pos_i;

    // Walk the five inputs starting just after rr_last; first hit wins.
    always_comb begin
        gnt     = 5'b00000;
        index   = 3'd0;
        found_s = 1'b0;
        pos_i   = 0;
        pos_s   = 3'd0;
        // Out-of-range history values behave like "input 4 was last".
        if (rr_last > 3'd4) begin
            base_s = 3'd4;
        end else begin
            base_s = rr_last;
        end
        for (int k = 1; k <= NIN; k++) begin
            pos_i = int'(base_s) + k;
            if (pos_i >= NIN) begin
                pos_i = pos_i - NIN;
            end else begin
                pos_i = pos_i;
            end
            pos_s = 3'(pos_i);
            if (!found_s && cand[pos_s]) begin
                found_s    = 1'b1;
                gnt[pos_s] = 1'b1;
                index      = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/outputc.sv
// Router output-channel stage.
//   Arbitrates the five input channels targeting physical port PCHID, holds a
//   wormhole lock on the granted output VC from head to tail, and registers the
//   owner's flits onto the outgoing link.
//   Ports:
//     clk, rst_                 clock, asynchronous active-low reset
//     idata_N/ivalid_N/ivch_N   flit, valid and requested VC from input N
//     req_N/port_N              switch request and requested port from input N
//     irdy                      per-VC downstream ready (whole packet fits)
//     grt_N                     registered grant to input N
//     odata/ovalid/ovch         registered link flit, valid and VC
//     ordy/olck                 per-VC ready (pass-through) and lock status
//   ROUTERID is for tracing only; PCHID selects which requests are ours.
module outputc
    import outputc_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PCHID    = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [DATAW:0]   idata_0,
    input  logic [DATAW:0]   idata_1,
    input  logic [DATAW:0]   idata_2,
    input  logic [DATAW:0]   idata_3,
    input  logic [DATAW:0]   idata_4,
    input  logic             ivalid_0,
    input  logic             ivalid_1,
    input  logic             ivalid_2,
    input  logic             ivalid_3,
    input  logic             ivalid_4,
    input  logic [VCHW:0]    ivch_0,
    input  logic [VCHW:0]    ivch_1,
    input  logic [VCHW:0]    ivch_2,
    input  logic [VCHW:0]    ivch_3,
    input  logic [VCHW:0]    ivch_4,
    input  logic             req_0,
    input  logic             req_1,
    input  logic             req_2,
    input  logic             req_3,
    input  logic             req_4,
    input  logic [PORTW:0]   port_0,
    input  logic [PORTW:0]   port_1,
    input  logic [PORTW:0]   port_2,
    input  logic [PORTW:0]   port_3,
    input  logic [PORTW:0]   port_4,
    input  logic [VCH:0]     irdy,
    output logic             grt_0,
    output logic             grt_1,
    output logic             grt_2,
    output logic             grt_3,
    output logic             grt_4,
    output logic [DATAW:0]   odata,
    output logic             ovalid,
    output logic [VCHW:0]    ovch,
    output logic [VCH:0]     ordy,
    output logic [VCH:0]     olck
);

    if (PCHID < 0 || PCHID > 4) begin : g_bad_pchid
        $error("outputc: PCHID must be in 0..4");
    end
    if (ROUTERID < 0) begin : g_bad_routerid
        $error("outputc: ROUTERID must be non-negative");
    end

    localparam logic [PORTW:0] MY_PORT = PCHID[PORTW:0];

    logic [DATAW:0] idata_s [NIN];
    logic [VCHW:0]  ivch_s  [NIN];
    logic [PORTW:0] port_s  [NIN];
    logic [4:0]     ivalid_s;
    logic [4:0]     req_s;

    assign idata_s[0] = idata_0;
    assign idata_s[1] = idata_1;
    assign idata_s[2] = idata_2;
    assign idata_s[3] = idata_3;
    assign idata_s[4] = idata_4;
    assign ivch_s[0]  = ivch_0;
    assign ivch_s[1]  = ivch_1;
    assign ivch_s[2]  = ivch_2;
    assign ivch_s[3]  = ivch_3;
    assign ivch_s[4]  = ivch_4;
    assign port_s[0]  = port_0;
    assign port_s[1]  = port_1;
    assign port_s[2]  = port_2;
    assign port_s[3]  = port_3;
    assign port_s[4]  = port_4;
    assign ivalid_s   = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
    assign req_s      = {req_4, req_3, req_2, req_1, req_0};

    state_e          state_r,   state_nxt_s;
    logic [2:0]      owner_r,   owner_nxt_s;
    logic [2:0]      rr_last_r, rr_last_nxt_s;
    logic [VCHW:0]   lvch_r,    lvch_nxt_s;
    logic [VCH:0]    olck_r,    olck_nxt_s;
    logic [4:0]      grt_r,     grt_nxt_s;
    logic [DATAW:0]  odata_r;
    logic            ovalid_r;
    logic [VCHW:0]   ovch_r;

    logic            owner_ok_s;
    logic            accept_s;
    logic            tail_s;
    logic            arb_en_s;
    logic            do_grant_s;
    logic [VCH:0]    lck_eff_s;
    logic [4:0]      cand_s;
    logic [4:0]      gnt_s;
    logic [2:0]      gidx_s;

    // Owner-side flit acceptance and tail detection for the current cycle.
    always_comb begin
        owner_ok_s = (owner_r < 3'd5);
        if ((state_r == ST_BUSY) && owner_ok_s) begin
            accept_s = ivalid_s[owner_r];
            tail_s   = ivalid_s[owner_r] && is_tail(idata_s[owner_r]);
        end else begin
            accept_s = 1'b0;
            tail_s   = 1'b0;
        end
    end

    // Candidate qualification; the VC being released by a tail counts as
    // free already, which lets the next packet be granted without a bubble.
    always_comb begin
        lck_eff_s = olck_r;
        if (tail_s) begin
            lck_eff_s[lvch_r] = 1'b0;
        end else begin
            lck_eff_s = olck_r;
        end
        for (int n = 0; n < NIN; n++) begin
            cand_s[n] = req_s[n] && (port_s[n] == MY_PORT)
                        && irdy[ivch_s[n]] && !lck_eff_s[ivch_s[n]];
        end
    end

    // rr_last_r already holds the current owner, so on a tail the owner
    // is automatically last in priority and wins only when it is alone.
    rr_arb5 u_arb (
        .cand    (cand_s),
        .rr_last (rr_last_r),
        .gnt     (gnt_s),
        .index   (gidx_s)
    );

    assign arb_en_s   = (state_r == ST_IDLE) || tail_s;
    assign do_grant_s = arb_en_s && (|gnt_s);

    // Next-state logic: grant, hold the wormhole lock, or release on a tail.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        rr_last_nxt_s = rr_last_r;
        lvch_nxt_s    = lvch_r;
        olck_nxt_s    = olck_r;
        grt_nxt_s     = grt_r;
        case (state_r)
            ST_IDLE: begin
                if (do_grant_s) begin
                    state_nxt_s                   = ST_BUSY;
                    owner_nxt_s                   = gidx_s;
                    rr_last_nxt_s                 = gidx_s;
                    lvch_nxt_s                    = ivch_s[gidx_s];
                    olck_nxt_s                    = '0;
                    olck_nxt_s[ivch_s[gidx_s]]    = 1'b1;
                    grt_nxt_s                     = gnt_s;
                end else begin
                    olck_nxt_s = '0;
                    grt_nxt_s  = 5'b00000;
                end
            end
            ST_BUSY: begin
                if (do_grant_s) begin
                    state_nxt_s                   = ST_BUSY;
                    owner_nxt_s                   = gidx_s;
                    rr_last_nxt_s                 = gidx_s;
                    lvch_nxt_s                    = ivch_s[gidx_s];
                    olck_nxt_s                    = '0;
                    olck_nxt_s[ivch_s[gidx_s]]    = 1'b1;
                    grt_nxt_s                     = gnt_s;
                end else if (tail_s) begin
                    state_nxt_s = ST_IDLE;
                    olck_nxt_s  = '0;
                    grt_nxt_s   = 5'b00000;
                end else begin
                    // Wormhole: hold grant and lock regardless of req/irdy.
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                owner_nxt_s   = 3'd0;
                rr_last_nxt_s = 3'd4;
                lvch_nxt_s    = '0;
                olck_nxt_s    = '0;
                grt_nxt_s     = 5'b00000;
            end
        endcase
    end

    // Arbitration/lock state registers.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_r   <= ST_IDLE;
            owner_r   <= 3'd0;
            rr_last_r <= 3'd4;
            lvch_r    <= '0;
            olck_r    <= '0;
            grt_r     <= 5'b00000;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            rr_last_r <= rr_last_nxt_s;
            lvch_r    <= lvch_nxt_s;
            olck_r    <= olck_nxt_s;
            grt_r     <= grt_nxt_s;
        end
    end

    // Link register: only the owner's accepted flit ever reaches odata.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            odata_r  <= '0;
            ovalid_r <= 1'b0;
            ovch_r   <= '0;
        end else if (accept_s) begin
            odata_r  <= idata_s[owner_r];
            ovalid_r <= 1'b1;
            ovch_r   <= lvch_r;
        end else begin
            odata_r  <= '0;
            ovalid_r <= 1'b0;
            ovch_r   <= '0;
        end
    end

    assign grt_0  = grt_r[0];
    assign grt_1  = grt_r[1];
    assign grt_2  = grt_r[2];
    assign grt_3  = grt_r[3];
    assign grt_4  = grt_r[4];
    assign odata  = odata_r;
    assign ovalid = ovalid_r;
    assign ovch   = ovch_r;
    assign olck   = olck_r;
    assign ordy   = irdy;

endmodule

// File: tb/tb_outputc.sv
// Scoreboard bench for outputc: randomized input-channel traffic, a
// packet-level reference model, and a monitor that checks every link cycle.
module tb_outputc;
    import outputc_pkg::*;

    localparam int PCH = 2;

    logic        clk;
    logic        rst_;
    logic [31:0] idata  [5];
    logic        ivalid [5];
    logic [0:0]  ivch   [5];
    logic        req    [5];
    logic [2:0]  port   [5];
    logic [1:0]  irdy;
    logic        grt    [5];
    logic [31:0] odata;
    logic        ovalid;
    logic [0:0]  ovch;
    logic [1:0]  ordy;
    logic [1:0]  olck;

    outputc #(.ROUTERID(7), .PCHID(PCH)) dut (
        .clk(clk), .rst_(rst_),
        .idata_0(idata[0]), .idata_1(idata[1]), .idata_2(idata[2]),
        .idata_3(idata[3]), .idata_4(idata[4]),
        .ivalid_0(ivalid[0]), .ivalid_1(ivalid[1]), .ivalid_2(ivalid[2]),
        .ivalid_3(ivalid[3]), .ivalid_4(ivalid[4]),
        .ivch_0(ivch[0]), .ivch_1(ivch[1]), .ivch_2(ivch[2]),
        .ivch_3(ivch[3]), .ivch_4(ivch[4]),
        .req_0(req[0]), .req_1(req[1]), .req_2(req[2]),
        .req_3(req[3]), .req_4(req[4]),
        .port_0(port[0]), .port_1(port[1]), .port_2(port[2]),
        .port_3(port[3]), .port_4(port[4]),
        .irdy(irdy),
        .grt_0(grt[0]), .grt_1(grt[1]), .grt_2(grt[2]),
        .grt_3(grt[3]), .grt_4(grt[4]),
        .odata(odata), .ovalid(ovalid), .ovch(ovch),
        .ordy(ordy), .olck(olck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] grt;
        logic [1:0] olck;
        logic       ovalid;
        logic [1:0] ordy;
    } ctl_t;

    typedef struct {
        logic [31:0] data;
        logic [0:0]  vc;
    } flit_t;

    ctl_t  ctl_q  [$];
    flit_t flit_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the link, its VC, and who was granted last.
    int m_owner = -1;
    int m_vc    = 0;
    int m_last  = 4;

    // Per-input packet sources.
    bit has_pkt [5];
    int len     [5];
    int sent    [5];
    int pvc     [5];
    int prt     [5];

    // Traffic knobs.
    int en_mask   = 0;
    int p_start   = 0;
    int p_send    = 100;
    int irdy_mode = 1;
    int p_other   = 0;
    int len_min   = 1;
    int len_max   = 1;
    int fixed_vc  = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of input-channel behaviour from the model's view of ownership.
    task automatic drive_cycle();
        for (int i = 0; i < 5; i++) begin
            if (!has_pkt[i] && en_mask[i] && ($urandom_range(0, 99) < p_start)) begin
                has_pkt[i] = 1'b1;
                len[i]     = $urandom_range(len_min, len_max);
                sent[i]    = 0;
                pvc[i]     = (fixed_vc >= 0) ? fixed_vc : $urandom_range(0, 1);
                prt[i]     = ($urandom_range(0, 99) < p_other) ? ((PCH + $urandom_range(1, 4)) % 5) : PCH;
            end
            idata[i]  = $urandom();
            ivch[i]   = pvc[i][0:0];
            port[i]   = prt[i][2:0];
            req[i]    = 1'b0;
            ivalid[i] = 1'b0;
            if (m_owner == i) begin
                if (has_pkt[i] && ($urandom_range(0, 99) < p_send)) begin
                    logic [1:0] ty;
                    if (len[i] == 1)                ty = TYPE_HEADTAIL;
                    else if (sent[i] == 0)          ty = TYPE_HEAD;
                    else if (sent[i] == len[i] - 1) ty = TYPE_TAIL;
                    else                            ty = TYPE_BODY;
                    idata[i][1:0] = ty;
                    ivalid[i]     = 1'b1;
                    sent[i]++;
                    if (sent[i] == len[i]) begin
                        has_pkt[i] = 1'b0;
                        req[i]     = 1'b0;
                    end else begin
                        req[i] = 1'($urandom_range(0, 1));
                    end
                end else begin
                    req[i] = 1'($urandom_range(0, 1));
                end
            end else begin
                if (has_pkt[i] && prt[i] != PCH && $urandom_range(0, 99) < 25)
                    has_pkt[i] = 1'b0;
                req[i]    = has_pkt[i];
                ivalid[i] = 1'($urandom_range(0, 1));
            end
        end
        case (irdy_mode)
            0:       irdy = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            2:       irdy = 2'b00;
            default: irdy = 2'b11;
        endcase
    endtask

    // Apply the output-channel rules to this cycle's inputs and queue the
    // responses the DUT must show after the next rising edge.
    task automatic model_step();
        bit   acc, tl;
        int   pick;
        ctl_t e;
        acc  = 1'b0;
        tl   = 1'b0;
        pick = -1;
        if (m_owner >= 0 && ivalid[m_owner]) begin
            flit_t f;
            acc    = 1'b1;
            tl     = (idata[m_owner][1:0] == TYPE_TAIL) || (idata[m_owner][1:0] == TYPE_HEADTAIL);
            f.data = idata[m_owner];
            f.vc   = m_vc[0:0];
            flit_q.push_back(f);
        end
        if (m_owner < 0 || tl) begin
            // At most one VC is ever locked, and it is free whenever we arbitrate.
            for (int k = 1; k <= 5 && pick < 0; k++) begin
                int c;
                c = (m_last + k) % 5;
                if (req[c] && port[c] == PCH && irdy[ivch[c]]) pick = c;
            end
        end
        if (pick >= 0) begin
            m_owner = pick;
            m_vc    = int'(ivch[pick]);
            m_last  = pick;
        end else if (tl) begin
            m_owner = -1;
        end
        e.grt    = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b00000;
        e.olck   = (m_owner >= 0) ? 2'(1 << m_vc) : 2'b00;
        e.ovalid = acc;
        e.ordy   = irdy;
        ctl_q.push_back(e);
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            drive_cycle();
            model_step();
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (m_owner >= 0);
        for (int i = 0; i < 5; i++)
            if (has_pkt[i] && prt[i] == PCH) p = 1'b1;
        return p;
    endfunction

    function automatic logic [4:0] grt_vec();
        return {grt[4], grt[3], grt[2], grt[1], grt[0]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grt"},    64'(grt_vec()), 64'd0);
        check({tag, "_odata"},  64'(odata),     64'd0);
        check({tag, "_ovalid"}, 64'(ovalid),    64'd0);
        check({tag, "_ovch"},   64'(ovch),      64'd0);
        check({tag, "_olck"},   64'(olck),      64'd0);
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 5; i++) begin
            has_pkt[i] = 1'b0;
            req[i]     = 1'b0;
            ivalid[i]  = 1'b0;
            idata[i]   = 32'd0;
            ivch[i]    = 1'b0;
            port[i]    = 3'd0;
            pvc[i]     = 0;
            prt[i]     = 0;
        end
    endtask

    // Monitor: compare every post-edge cycle against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (rst_ && ctl_q.size() > 0) begin
            ctl_t e;
            e = ctl_q.pop_front();
            check("grt",    64'(grt_vec()), 64'(e.grt));
            check("olck",   64'(olck),      64'(e.olck));
            check("ovalid", 64'(ovalid),    64'(e.ovalid));
            check("ordy",   64'(ordy),      64'(e.ordy));
            if (ovalid) begin
                if (flit_q.size() == 0) begin
                    check("flit_q_nonempty", 64'd0, 64'd1);
                end else begin
                    flit_t f;
                    f = flit_q.pop_front();
                    check("odata", 64'(odata), 64'(f.data));
                    check("ovch",  64'(ovch),  64'(f.vc));
                end
            end else begin
                check("odata_idle", 64'(odata), 64'd0);
            end
        end
    end

    initial begin
        int guard;
        rst_ = 1'b0;
        irdy = 2'b11;
        clear_sources();
        #23;
        check_reset_outputs("reset");

        @(negedge clk);
        rst_ = 1'b1;

        // Single HEADTAIL packet from input 2 on VC 0.
        en_mask = 5'b00100; p_start = 100; len_min = 1; len_max = 1;
        fixed_vc = 0; irdy_mode = 1; p_send = 100;
        run_cycles(1);
        en_mask = 0;
        run_cycles(6);

        // Inputs 0 and 3 contend with 3-flit packets: back-to-back hand-over.
        en_mask = 5'b01001; p_start = 100; len_min = 3; len_max = 3; fixed_vc = -1;
        run_cycles(20);
        en_mask = 0;
        run_cycles(10);

        // Input 1 waits while irdy is low, then is granted once it rises.
        en_mask = 5'b00010; p_start = 100; len_min = 2; len_max = 2;
        irdy_mode = 2;
        run_cycles(8);
        irdy_mode = 1; en_mask = 0;
        run_cycles(8);

        // Input 4 with a sparse sender: gaps in ivalid mid-packet.
        en_mask = 5'b10000; p_start = 100; len_min = 4; len_max = 4; p_send = 25;
        run_cycles(40);
        en_mask = 0; p_send = 100;
        run_cycles(10);

        // Fully random traffic, wrong-port requests and irdy dropouts.
        en_mask = 5'b11111; p_start = 30; len_min = 1; len_max = 5;
        p_send = 70; irdy_mode = 0; p_other = 20;
        run_cycles(1500);

        // Reset in the middle of a packet.
        guard = 0;
        while ((m_owner < 0 || sent[m_owner] == 0) && guard < 200) begin
            run_cycles(1);
            guard++;
        end
        check("midpkt_found", 64'(guard < 200), 64'd1);
        @(negedge clk);
        #2;
        rst_ = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        ctl_q.delete();
        flit_q.delete();
        m_owner = -1; m_vc = 0; m_last = 4;
        clear_sources();
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;

        // After reset input 0 is first in line.
        en_mask = 5'b00001; p_start = 100; len_min = 2; len_max = 2;
        p_send = 100; irdy_mode = 1; p_other = 0;
        drive_cycle();
        model_step();
        en_mask = 5'b11111; p_start = 20;
        run_cycles(200);

        // Drain.
        en_mask = 0; irdy_mode = 1; p_send = 100;
        guard = 0;
        while (pending() && guard < 300) begin
            run_cycles(1);
            guard++;
        end
        check("drain_done", 64'(pending()), 64'd0);
        run_cycles(3);
        @(posedge clk);
        #2;
        check("flit_q_empty", 64'(flit_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
